// File: rtl/hsync_provider.sv
// rtl/hsync_provider.sv - horizontal timing stage of the VGA chain
//
// Purpose:
//   Divides the system clock down to the pixel rate, counts pixels across a
//   line, tracks the line segment (front porch, sync, back porch, visible)
//   in a state register and produces registered HSYNC, X, visible and the
//   new_row strobe that clocks the vertical stage.
//
// Ports:
//   clk        in   1   system clock, all logic on posedge
//   reset      in   1   synchronous, active-low reset (priority over enable)
//   enable     in   1   1 = run, 0 = freeze all state
//   pixel_tick out  1   one-clk pulse per pixel period
//   HSYNC      out  1   horizontal sync, asserted level = HSYNC_POL
//   new_row    out  1   high for one pixel period at the start of each line
//   X          out  10  visible column, 0 outside the visible segment
//   visible    out  1   1 while in the visible segment

module hsync_provider #(
   parameter int PIX_DIV              = 4,
   parameter int HorizontalFrontPorch = 16,
   parameter int HSYNCPulse           = 96,
   parameter int HorizontalBackPorch  = 48,
   parameter int VisiblePixels        = 640,
   parameter bit HSYNC_POL            = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   output logic       pixel_tick,
   output logic       HSYNC,
   output logic       new_row,
   output logic [9:0] X,
   output logic       visible
);

   localparam int LINE    = HorizontalFrontPorch + HSYNCPulse + HorizontalBackPorch + VisiblePixels;
   localparam int H_SYNC0 = HorizontalFrontPorch;
   localparam int H_BACK0 = HorizontalFrontPorch + HSYNCPulse;
   localparam int H_VIS0  = LINE - VisiblePixels;

   // A one-bit divider is kept for PIX_DIV=1; it simply stays at zero.
   localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

   typedef enum logic [1:0] {
      S_FRONT,
      S_SYNC,
      S_BACK,
      S_VISIBLE
   } seg_t;

   seg_t             state;
   seg_t             state_nxt;
   logic [DIV_W-1:0] div_cnt;
   logic [9:0]       h_count;
   logic [9:0]       h_nxt;
   logic             advance;
   logic             hsync_nxt;
   logic             visible_nxt;
   logic             new_row_nxt;
   logic [9:0]       x_nxt;

   // h_count and every output move only on this edge, so disabling the
   // block between a tick and its advance cannot split an update.
   assign advance = enable & pixel_tick;

   // Pixel divider: pixel_tick is a registered pulse in the clk after the
   // divider reaches its last count. A disabled clk clears the pulse but
   // leaves div_cnt where it was, so the pixel phase resumes unchanged.
   always_ff @(posedge clk) begin
      if (!reset) begin
         div_cnt    <= '0;
         pixel_tick <= 1'b0;
      end else if (enable) begin
         if (div_cnt == DIV_LAST) begin
            div_cnt    <= '0;
            pixel_tick <= 1'b1;
         end else begin
            div_cnt    <= div_cnt + 1'b1;
            pixel_tick <= 1'b0;
         end
      end else begin
         pixel_tick <= 1'b0;
      end
   end

   // Segment FSM state register plus the line counter and registered
   // outputs; all load from the same next-pixel values on an advance.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= S_FRONT;
         h_count <= '0;
         HSYNC   <= ~HSYNC_POL;
         visible <= 1'b0;
         X       <= '0;
         new_row <= 1'b0;
      end else if (advance) begin
         state   <= state_nxt;
         h_count <= h_nxt;
         HSYNC   <= hsync_nxt;
         visible <= visible_nxt;
         X       <= x_nxt;
         new_row <= new_row_nxt;
      end
   end

   // Next-state and next-output logic. Outputs are computed from the value
   // the counter and FSM are about to take, which is what removes the extra
   // cycle of latency a decode of the current registers would add.
   always_comb begin
      h_nxt       = '0;
      state_nxt   = state;
      hsync_nxt   = ~HSYNC_POL;
      visible_nxt = 1'b0;
      x_nxt       = '0;
      new_row_nxt = 1'b0;

      if (h_count != 10'(LINE - 1)) begin
         h_nxt = h_count + 10'd1;
      end

      case (state)
         S_FRONT: begin
            if (h_nxt == 10'(H_SYNC0)) begin
               state_nxt = S_SYNC;
            end
         end
         S_SYNC: begin
            if (h_nxt == 10'(H_BACK0)) begin
               state_nxt = S_BACK;
            end
         end
         S_BACK: begin
            if (h_nxt == 10'(H_VIS0)) begin
               state_nxt = S_VISIBLE;
            end
         end
         S_VISIBLE: begin
            if (h_nxt == 10'd0) begin
               state_nxt = S_FRONT;
            end
         end
         default: begin
            state_nxt = S_FRONT;
         end
      endcase

      if (state_nxt == S_SYNC) begin
         hsync_nxt = HSYNC_POL;
      end

      if (state_nxt == S_VISIBLE) begin
         visible_nxt = 1'b1;
         x_nxt       = h_nxt - 10'(H_VIS0);
      end

      // High only for pixel 0 of a line; the 0->1 advance clears it. Reset
      // also leaves it low, so the first rising edge is at the first wrap.
      new_row_nxt = (h_nxt == 10'd0);
   end

endmodule
